// File: rtl/mfp_uart_transmitter.sv
// mfp_uart_transmitter: FIFO-buffered UART transmitter, 8N1 frames, 8E1 when MFP_UART_TX_PARITY_EN is defined
module mfp_uart_transmitter #(
  parameter int clock_frequency = 50000000,
  parameter int baud_rate       = 115200,
  parameter int fifo_depth_log2 = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] byte_data,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       tx,
  output logic       busy
);
  localparam int cycles = clock_frequency / baud_rate;
  localparam int cw = $clog2(cycles);
  localparam int aw = fifo_depth_log2;
  localparam logic [cw-1:0] cnt_max = cw'(cycles - 1);
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef MFP_UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;
  state_t state_q, state_d;
  logic [7:0] mem_q [0:(1<<aw)-1];
  logic [aw:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [cw-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic tx_q, tx_d, busy_q, busy_d;
`ifdef MFP_UART_TX_PARITY_EN
  logic par_q, par_d;
`endif
  logic empty, full, push, pop, sym_end;
  assign empty = wptr_q == rptr_q;
  assign full = (wptr_q[aw] != rptr_q[aw]) && (wptr_q[aw-1:0] == rptr_q[aw-1:0]);
  assign byte_ready = !full;
  assign push = byte_valid & !full;
  assign sym_end = cnt_q == '0;
  assign tx = tx_q;
  assign busy = busy_q;
  // Next-state: the counter sits at 0 in IDLE, so a symbol boundary is any cycle with cnt 0 that leads to a non-IDLE state
  always_comb begin
    state_d = state_q;
    cnt_d = sym_end ? cnt_q : cnt_q - 1'b1;
    bit_d = bit_q;
    shift_d = shift_q;
    pop = 1'b0;
`ifdef MFP_UART_TX_PARITY_EN
    par_d = par_q;
`endif
    case (state_q)
      IDLE: pop = !empty;
      START: if (sym_end) begin
        state_d = DATA;
        bit_d = '0;
      end
      DATA: if (sym_end) begin
        shift_d = shift_q >> 1;
        bit_d = bit_q + 1'b1;
`ifdef MFP_UART_TX_PARITY_EN
        state_d = (bit_q == 3'd7) ? PARITY : DATA;
`else
        state_d = (bit_q == 3'd7) ? STOP : DATA;
`endif
      end
`ifdef MFP_UART_TX_PARITY_EN
      PARITY: if (sym_end) state_d = STOP;
`endif
      STOP: if (sym_end) begin
        pop = !empty;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (pop) begin
      state_d = START;
      shift_d = mem_q[rptr_q[aw-1:0]];
`ifdef MFP_UART_TX_PARITY_EN
      par_d = ^mem_q[rptr_q[aw-1:0]];
`endif
    end
    if (sym_end && state_d != IDLE) cnt_d = cnt_max;
    wptr_d = wptr_q + {{aw{1'b0}}, push};
    rptr_d = rptr_q + {{aw{1'b0}}, pop};
    busy_d = (state_d != IDLE) || (wptr_d != rptr_d);
    tx_d = (state_d == START) ? 1'b0 :
           (state_d == DATA) ? shift_d[0] :
`ifdef MFP_UART_TX_PARITY_EN
           (state_d == PARITY) ? par_d :
`endif
           1'b1;
  end
  // State, line and FIFO pointer registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      tx_q <= 1'b1;
      busy_q <= 1'b0;
      wptr_q <= '0;
      rptr_q <= '0;
`ifdef MFP_UART_TX_PARITY_EN
      par_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      tx_q <= tx_d;
      busy_q <= busy_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
`ifdef MFP_UART_TX_PARITY_EN
      par_q <= par_d;
`endif
    end
  end
  // FIFO storage; contents need no reset since the pointers define validity
  always_ff @(posedge clock) begin
    if (push) mem_q[wptr_q[aw-1:0]] <= byte_data;
  end
endmodule

// File: tb/tb_mfp_uart_transmitter.sv
// tb_mfp_uart_transmitter: directed self-checking bench for mfp_uart_transmitter at 10 cycles per symbol
module tb_mfp_uart_transmitter;
  localparam int CYC = 10;
`ifdef MFP_UART_TX_PARITY_EN
  localparam int NSYM = 11;
`else
  localparam int NSYM = 10;
`endif
  localparam int FL = NSYM * CYC;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic [7:0] byte_data = '0;
  logic byte_valid = 1'b0;
  logic byte_ready, tx, busy;
  int errors = 0;
  int checks = 0;

  mfp_uart_transmitter #(
    .clock_frequency(1000),
    .baud_rate(100),
    .fifo_depth_log2(2)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .byte_data(byte_data),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .tx(tx),
    .busy(busy)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Symbol k of the frame is bit k: start, 8 data bits LSB first, optional even parity, stop
  function automatic logic [10:0] frame_bits(input logic [7:0] b);
`ifdef MFP_UART_TX_PARITY_EN
    return {1'b1, ^b, b, 1'b0};
`else
    return {2'b11, b, 1'b0};
`endif
  endfunction

  // Samples frame cycles [from, to) of the current frame, ticking after each sample
  task automatic expect_frame(input logic [7:0] b, input int from, input int to);
    logic [10:0] s;
    int bad_tx, bad_busy;
    s = frame_bits(b);
    bad_tx = 0;
    bad_busy = 0;
    for (int c = from; c < to; c++) begin
      if (tx !== s[c / CYC]) bad_tx++;
      if (busy !== 1'b1) bad_busy++;
      tick();
    end
    chk($sformatf("frame_%02h_tx_bad_cycles", b), bad_tx, 0);
    chk($sformatf("frame_%02h_busy_low_cycles", b), bad_busy, 0);
  endtask

  initial begin
    int bad;
    tick();
    tick();
    chk("reset_tx", tx, 1);
    chk("reset_ready", byte_ready, 1);
    chk("reset_busy", busy, 0);
    reset_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (tx !== 1'b1 || byte_ready !== 1'b1 || busy !== 1'b0) bad++;
      tick();
    end
    chk("idle_50_bad_cycles", bad, 0);

    byte_valid = 1'b1;
    byte_data = 8'hA5;
    tick();
    byte_valid = 1'b0;
    chk("a5_tx_before_pop", tx, 1);
    chk("a5_busy_after_accept", busy, 1);
    tick();
    chk("a5_tx_falls", tx, 0);
    expect_frame(8'hA5, 0, FL);
    chk("a5_busy_done", busy, 0);
    chk("a5_tx_idle", tx, 1);

    byte_valid = 1'b1;
    byte_data = 8'h00;
    tick();
    chk("burst_ready_1", byte_ready, 1);
    byte_data = 8'hFF;
    tick();
    chk("burst_start_00", tx, 0);
    byte_data = 8'h55;
    tick();
    byte_data = 8'h0F;
    tick();
    byte_data = 8'h33;
    tick();
    chk("burst_ready_full", byte_ready, 0);
    byte_data = 8'hC3;
    expect_frame(8'h00, 3, FL);
    chk("burst_ready_after_pop", byte_ready, 1);
    chk("burst_no_gap", tx, 0);
    tick();
    chk("burst_ready_refull", byte_ready, 0);
    byte_valid = 1'b0;
    expect_frame(8'hFF, 1, FL);
    expect_frame(8'h55, 0, FL);
    expect_frame(8'h0F, 0, FL);
    expect_frame(8'h33, 0, FL);
    expect_frame(8'hC3, 0, FL);
    chk("burst_busy_done", busy, 0);
    chk("burst_tx_idle", tx, 1);

    byte_valid = 1'b1;
    byte_data = 8'h3C;
    tick();
    byte_data = 8'h81;
    tick();
    byte_data = 8'h96;
    tick();
    byte_valid = 1'b0;
    expect_frame(8'h3C, 1, FL - 1);
    byte_valid = 1'b1;
    byte_data = 8'h6A;
    expect_frame(8'h3C, FL - 1, FL);
    byte_valid = 1'b0;
    chk("coincide_ready", byte_ready, 1);
    expect_frame(8'h81, 0, FL);
    expect_frame(8'h96, 0, FL);
    expect_frame(8'h6A, 0, FL);
    chk("coincide_busy_done", busy, 0);

    byte_valid = 1'b1;
    byte_data = 8'hE7;
    tick();
    byte_data = 8'h18;
    tick();
    byte_data = 8'h24;
    tick();
    byte_valid = 1'b0;
    expect_frame(8'hE7, 1, 35);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("midreset_tx", tx, 1);
    chk("midreset_busy", busy, 0);
    chk("midreset_ready", byte_ready, 1);
    bad = 0;
    for (int i = 0; i < 2 * FL; i++) begin
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
      tick();
    end
    chk("midreset_quiet_bad_cycles", bad, 0);

`ifdef MFP_UART_TX_PARITY_EN
    byte_valid = 1'b1;
    byte_data = 8'h07;
    tick();
    byte_valid = 1'b0;
    tick();
    chk("par07_tx_falls", tx, 0);
    expect_frame(8'h07, 0, FL);
    chk("par07_busy_done", busy, 0);
    byte_valid = 1'b1;
    byte_data = 8'h03;
    tick();
    byte_valid = 1'b0;
    tick();
    chk("par03_tx_falls", tx, 0);
    expect_frame(8'h03, 0, FL);
    chk("par03_busy_done", busy, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
